soc2_send_req_ctrl: RTL and testbench
=====================================

// Module: soc2_send_req_ctrl
// PURPOSE
//  Avalon-MM slave that lets the CPU originate a four-phase req/ack handshake toward the peer SoC.
//  It is the transmit end of the link whose peer end samples our req_out through its input PIO.
//  CPU loads a payload and issues start. Block drives data_out + req_out and waits for ack_in rise/fall.
//  Completion, timeout and busy-error are reported as sticky status bits and an optional irq.
// PARAMETERS
//  DATA_W       8   payload width driven on data_out (1..32)
//  TO_W        16   timeout counter width; TIMEOUT reg holds TO_W bits
//  SYNC_STAGES  2   flops in ack_in synchronizer (>=2)
// PORTS
//  clk          in   1       system clock
//  reset_n      in   1       asynchronous, active-low reset
//  address      in   2       word address: 0 DATA, 1 CONTROL, 2 STATUS, 3 TIMEOUT
//  chipselect   in   1       slave select
//  write_n      in   1       active-low write strobe, qualified by chipselect
//  writedata    in   32      write data
//  readdata     out  32      registered read data
//  ack_in       in   1       peer acknowledge, asynchronous to clk
//  req_out      out  1       request to peer, registered
//  data_out     out  DATA_W  payload, stable whenever req_out=1
//  irq          out  1       level interrupt
// BEHAVIOUR
//  Reset: req_out=0, data_out=0, readdata=0, irq=0, all regs/status=0, FSM=IDLE, sync chain=0.
//  Write = chipselect & ~write_n. readdata <= mux(address) every clk: 1-cycle latency, no read strobe.
//  Unused bits read 0.
//  DATA (rw): [DATA_W-1:0] payload. Write while busy is ignored, so data_out never changes mid-handshake.
//  CONTROL: bit0 start (W1, self-clearing, reads 0); bit1 irq_en (rw); bit2 abort (W1, reads 0).
//  STATUS: bit0 busy (ro); bit1 done; bit2 timeout; bit3 err_busy; bit4 ack_sync (ro).
//   Bits 1-3 are sticky and W1C. A set event in the same cycle as a W1C clear leaves the bit set.
//  TIMEOUT (rw): [TO_W-1:0] cycle limit per phase; 0 disables timeout.
//  ack_s = ack_in after SYNC_STAGES flops. All FSM decisions use ack_s only.
//  FSM states:
//   IDLE:    start & ~ack_s -> data_out<=DATA, req_out<=1, cnt<=0, go ASSERT.
//            start & ack_s -> stay IDLE, set err_busy (peer not released).
//   ASSERT:  ack_s=1 -> req_out<=0, cnt<=0, go RELEASE; else cnt++.
//   RELEASE: ack_s=0 -> set done, go IDLE; else cnt++.
//  Timeout: in ASSERT/RELEASE, when TIMEOUT!=0 and cnt==TIMEOUT-1, set timeout, req_out<=0, go IDLE.
//   The ack check takes priority over timeout in the same cycle.
//  cnt saturates at all-ones and never wraps.
//  busy = (state!=IDLE). start while busy: ignored, set err_busy.
//  abort while busy: req_out<=0, go IDLE, no status bit. abort in IDLE has no effect.
//   abort and start in the same write: abort wins, start ignored.
//  Latency: start write at cycle N -> req_out=1 at N+1.
//   ack_in edge -> FSM reacts SYNC_STAGES+1 cycles later.
//  irq = irq_en & (done | timeout | err_busy), registered. Deasserts the cycle after the W1C clear.
//  Reset mid-handshake returns to IDLE with req_out=0. The peer must tolerate req dropping early.
// STRUCTURE
//  Package soc2_handshake_pkg holds:
//   register address constants (ADDR_DATA..ADDR_TIMEOUT);
//   CONTROL/STATUS bit indices;
//   the state encoding typedef (IDLE, ASSERT, RELEASE).
//  Sub-module soc2_bit_sync (SYNC_STAGES-deep flop chain, async reset to 0) for ack_in.
//  The rest is inline: register file, FSM, phase counter, read mux.
// TESTING
//  1 Normal: DATA=0xA5, start; peer acks 4 cycles after req and drops ack 3 cycles after req falls.
//    -> data_out=0xA5 for the whole handshake; STATUS=0x02 at the end; irq=0 because irq_en=0.
//  2 Timeout: TIMEOUT=10, peer never acks.
//    -> req_out high for exactly 10 cycles, then 0; STATUS.timeout=1; with irq_en=1, irq=1.
//    -> W1C 0x04 clears timeout and irq.
//  3 Busy collisions:
//    -> start during ASSERT sets err_busy and does not restart cnt.
//    -> DATA write of 0x3C during ASSERT leaves data_out and DATA unchanged.
//    -> start while ack_s=1 in IDLE sets err_busy and leaves req_out at 0.
//  4 Abort: abort in ASSERT -> req_out=0 next cycle, busy=0, done=0, timeout=0.
//    Abort+start written together in IDLE -> no handshake.
//  5 Reset: assert reset_n low during RELEASE -> all outputs 0 immediately;
//    after release, STATUS=0 and a new start works.
//  6 Sync/latency: toggle ack_in mid-cycle.
//    -> ack_sync reads new value after SYNC_STAGES+1 cycles; readdata follows address with 1-cycle latency.

Source files
------------

// File: rtl/soc2_send_req_ctrl_pkg.sv
// Shared constants and state encoding for the req/ack transmit controller.
// Register map, CONTROL/STATUS bit positions and the handshake FSM states.
package soc2_handshake_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_CONTROL = 2'd1;
    localparam logic [1:0] ADDR_STATUS  = 2'd2;
    localparam logic [1:0] ADDR_TIMEOUT = 2'd3;

    localparam int CTL_START  = 0;
    localparam int CTL_IRQ_EN = 1;
    localparam int CTL_ABORT  = 2;

    localparam int ST_BUSY     = 0;
    localparam int ST_DONE     = 1;
    localparam int ST_TIMEOUT  = 2;
    localparam int ST_ERR_BUSY = 3;
    localparam int ST_ACK_SYNC = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        RELEASE = 2'd2
    } state_t;

endpackage

// File: rtl/soc2_send_req_ctrl_if.sv
// Avalon-MM slave port plus the req/ack link toward the peer SoC.
// The slave modport is the controller side; master is the CPU/peer side.
interface soc2_send_req_ctrl_if #(
    parameter int DATA_W = 8
);
    logic [1:0]        address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic              ack_in;
    logic              req_out;
    logic [DATA_W-1:0] data_out;
    logic              irq;

    modport slave (
        input  address, chipselect, write_n, writedata, ack_in,
        output readdata, req_out, data_out, irq
    );

    modport master (
        output address, chipselect, write_n, writedata, ack_in,
        input  readdata, req_out, data_out, irq
    );
endinterface

// File: rtl/soc2_send_req_ctrl_bit_sync.sv
// Multi-flop synchronizer for a single asynchronous level.
// Chain clears to 0 on reset so a stale peer ack is never seen early.
module soc2_bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_d,
    output logic o_q
);
    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];
endmodule

// File: rtl/soc2_send_req_ctrl.sv
// CPU-driven transmit end of a four-phase req/ack link to the peer SoC.
// Register file, handshake FSM with per-phase timeout, sticky status, irq.
module soc2_send_req_ctrl
    import soc2_handshake_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int TO_W        = 16,
    parameter int SYNC_STAGES = 2
) (
    input logic                clk,
    input logic                reset_n,
    soc2_send_req_ctrl_if.slave bus
);
    state_t            r_state;
    logic              r_req;
    logic [DATA_W-1:0] r_data_out;
    logic [TO_W-1:0]   r_cnt;

    logic [DATA_W-1:0] r_data;
    logic              r_irq_en;
    logic [TO_W-1:0]   r_timeout;
    logic              r_done;
    logic              r_to;
    logic              r_err;
    logic              r_irq;
    logic [31:0]       r_readdata;

    logic              w_ack_s;
    logic              w_wr;
    logic              w_wr_data;
    logic              w_wr_ctl;
    logic              w_wr_st;
    logic              w_wr_to;
    logic              w_start;
    logic              w_abort;
    logic              w_go;
    logic              w_busy;
    logic              w_to_hit;
    logic [TO_W-1:0]   w_cnt_inc;
    logic              w_set_done;
    logic              w_set_to;
    logic              w_set_err;
    logic [31:0]       w_rd;

    soc2_bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_d     (bus.ack_in),
        .o_q     (w_ack_s)
    );

    assign w_wr      = bus.chipselect & ~bus.write_n;
    assign w_wr_data = w_wr & (bus.address == ADDR_DATA);
    assign w_wr_ctl  = w_wr & (bus.address == ADDR_CONTROL);
    assign w_wr_st   = w_wr & (bus.address == ADDR_STATUS);
    assign w_wr_to   = w_wr & (bus.address == ADDR_TIMEOUT);

    assign w_start = w_wr_ctl & bus.writedata[CTL_START];
    assign w_abort = w_wr_ctl & bus.writedata[CTL_ABORT];
    assign w_go    = w_start & ~w_abort;
    assign w_busy  = (r_state != IDLE);

    assign w_to_hit  = (r_timeout != '0) &&
                       (r_cnt == r_timeout - TO_W'(1));
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + TO_W'(1);

    // Ack wins over timeout; abort suppresses every status event.
    assign w_set_err  = w_go & (w_busy | w_ack_s);
    assign w_set_done = (r_state == RELEASE) & ~w_abort & ~w_ack_s;
    assign w_set_to   = ~w_abort & w_to_hit &
                        (((r_state == ASSERT) & ~w_ack_s) |
                         ((r_state == RELEASE) & w_ack_s));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_req      <= 1'b0;
            r_data_out <= '0;
            r_cnt      <= '0;
        end else if (w_abort && w_busy) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_go && !w_ack_s) begin
                        r_data_out <= r_data;
                        r_req      <= 1'b1;
                        r_cnt      <= '0;
                        r_state    <= ASSERT;
                    end
                end
                ASSERT: begin
                    if (w_ack_s) begin
                        r_req   <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= RELEASE;
                    end else if (w_to_hit) begin
                        r_req   <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                RELEASE: begin
                    if (!w_ack_s) begin
                        r_state <= IDLE;
                    end else if (w_to_hit) begin
                        r_req   <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                    r_req   <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Set beats clear when a status event and its W1C land together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data     <= '0;
            r_irq_en   <= 1'b0;
            r_timeout  <= '0;
            r_done     <= 1'b0;
            r_to       <= 1'b0;
            r_err      <= 1'b0;
            r_irq      <= 1'b0;
            r_readdata <= '0;
        end else begin
            if (w_wr_data && !w_busy) begin
                r_data <= bus.writedata[DATA_W-1:0];
            end
            if (w_wr_ctl) begin
                r_irq_en <= bus.writedata[CTL_IRQ_EN];
            end
            if (w_wr_to) begin
                r_timeout <= bus.writedata[TO_W-1:0];
            end
            r_done <= (r_done & ~(w_wr_st & bus.writedata[ST_DONE]))
                      | w_set_done;
            r_to   <= (r_to & ~(w_wr_st & bus.writedata[ST_TIMEOUT]))
                      | w_set_to;
            r_err  <= (r_err & ~(w_wr_st & bus.writedata[ST_ERR_BUSY]))
                      | w_set_err;
            r_irq      <= r_irq_en & (r_done | r_to | r_err);
            r_readdata <= w_rd;
        end
    end

    always_comb begin
        w_rd = '0;
        unique case (bus.address)
            ADDR_DATA:    w_rd[DATA_W-1:0] = r_data;
            ADDR_CONTROL: w_rd[CTL_IRQ_EN] = r_irq_en;
            ADDR_STATUS: begin
                w_rd[ST_BUSY]     = w_busy;
                w_rd[ST_DONE]     = r_done;
                w_rd[ST_TIMEOUT]  = r_to;
                w_rd[ST_ERR_BUSY] = r_err;
                w_rd[ST_ACK_SYNC] = w_ack_s;
            end
            ADDR_TIMEOUT: w_rd[TO_W-1:0] = r_timeout;
            default:      w_rd = '0;
        endcase
    end

    assign bus.readdata = r_readdata;
    assign bus.req_out  = r_req;
    assign bus.data_out = r_data_out;
    assign bus.irq      = r_irq;
endmodule

// File: tb/tb_soc2_send_req_ctrl.sv
// Directed bench for soc2_send_req_ctrl: one task per scenario.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_soc2_send_req_ctrl;
    import soc2_handshake_pkg::*;

    localparam int DW = 8;
    localparam int TW = 16;
    localparam int SS = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        hi_clr = 1'b0;
    int          req_hi = 0;
    int          passed = 0;
    int          total = 0;
    logic [31:0] v;

    soc2_send_req_ctrl_if #(.DATA_W(DW)) bus ();

    soc2_send_req_ctrl #(
        .DATA_W      (DW),
        .TO_W        (TW),
        .SYNC_STAGES (SS)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    // Counts rising edges seen with req_out high.
    always @(posedge clk) begin
        if (hi_clr) req_hi <= 0;
        else if (bus.req_out) req_hi <= req_hi + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1);
    end

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.address = a;
        bus.chipselect = 1'b1;
        bus.write_n = 1'b0;
        bus.writedata = d;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.address = a;
        bus.chipselect = 1'b1;
        bus.write_n = 1'b1;
        @(negedge clk);
        d = bus.readdata;
        bus.chipselect = 1'b0;
    endtask

    task automatic test_reset();
        logic [41:0] o;
        #1;
        o = {bus.req_out, bus.irq, bus.data_out, bus.readdata};
        total++;
        if (o !== 42'h0) $display("FAIL reset_outputs got %h exp 0", o);
        else passed++;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), v);
            total++;
            if (v !== 32'h0) $display("FAIL reset_reg%0d got %h exp 0", a, v);
            else passed++;
        end
    endtask

    task automatic test_normal();
        int bad = 0;
        int n = 0;
        int k = 0;
        wr(ADDR_DATA, 32'hA5);
        wr(ADDR_CONTROL, 32'h1);
        for (int i = 0; i < 4; i++) begin
            if (bus.req_out !== 1'b1 || bus.data_out !== 8'hA5) bad++;
            @(negedge clk);
        end
        bus.ack_in = 1'b1;
        while (bus.req_out === 1'b1 && n < 20) begin
            if (bus.data_out !== 8'hA5) bad++;
            @(negedge clk);
            n++;
        end
        total++;
        if (bad !== 0) $display("FAIL normal_data_hold got %0d bad exp 0", bad);
        else passed++;
        total++;
        if (n !== SS + 1) $display("FAIL normal_ack_latency got %0d exp %0d", n, SS + 1);
        else passed++;
        repeat (3) @(negedge clk);
        bus.ack_in = 1'b0;
        do begin
            rd(ADDR_STATUS, v);
            k++;
        end while (v[ST_BUSY] && k < 10);
        total++;
        if (v !== 32'h02) $display("FAIL normal_status got %h exp 02", v);
        else passed++;
        total++;
        if (bus.irq !== 1'b0) $display("FAIL normal_irq got %b exp 0", bus.irq);
        else passed++;
        wr(ADDR_STATUS, 32'h02);
    endtask

    task automatic test_timeout();
        int n = 0;
        wr(ADDR_TIMEOUT, 32'd10);
        wr(ADDR_CONTROL, 32'h3);
        while (bus.req_out === 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n !== 10) $display("FAIL timeout_req_len got %0d exp 10", n);
        else passed++;
        rd(ADDR_STATUS, v);
        total++;
        if (v !== 32'h04) $display("FAIL timeout_status got %h exp 04", v);
        else passed++;
        total++;
        if (bus.irq !== 1'b1) $display("FAIL timeout_irq got %b exp 1", bus.irq);
        else passed++;
        wr(ADDR_STATUS, 32'h04);
        total++;
        if (bus.irq !== 1'b1) $display("FAIL irq_hold_clr_cycle got %b exp 1", bus.irq);
        else passed++;
        @(negedge clk);
        total++;
        if (bus.irq !== 1'b0) $display("FAIL irq_after_w1c got %b exp 0", bus.irq);
        else passed++;
        rd(ADDR_STATUS, v);
        total++;
        if (v !== 32'h0) $display("FAIL timeout_cleared got %h exp 0", v);
        else passed++;
        wr(ADDR_CONTROL, 32'h0);
    endtask

    task automatic test_busy();
        int n = 0;
        wr(ADDR_TIMEOUT, 32'd20);
        @(negedge clk);
        hi_clr = 1'b1;
        @(negedge clk);
        hi_clr = 1'b0;
        wr(ADDR_DATA, 32'h11);
        wr(ADDR_CONTROL, 32'h1);
        repeat (3) @(negedge clk);
        wr(ADDR_CONTROL, 32'h1);
        wr(ADDR_DATA, 32'h3C);
        total++;
        if (bus.data_out !== 8'h11) $display("FAIL busy_data_out got %h exp 11", bus.data_out);
        else passed++;
        rd(ADDR_DATA, v);
        total++;
        if (v !== 32'h11) $display("FAIL busy_data_reg got %h exp 11", v);
        else passed++;
        rd(ADDR_STATUS, v);
        total++;
        if (v !== 32'h09) $display("FAIL busy_status got %h exp 09", v);
        else passed++;
        while (bus.req_out === 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (req_hi !== 20) $display("FAIL busy_cnt_kept got %0d exp 20", req_hi);
        else passed++;
        rd(ADDR_STATUS, v);
        total++;
        if (v !== 32'h0C) $display("FAIL busy_to_status got %h exp 0C", v);
        else passed++;
        wr(ADDR_STATUS, 32'h0E);
        wr(ADDR_TIMEOUT, 32'h0);
        bus.ack_in = 1'b1;
        repeat (4) @(negedge clk);
        wr(ADDR_CONTROL, 32'h1);
        repeat (2) @(negedge clk);
        total++;
        if (bus.req_out !== 1'b0) $display("FAIL ack_busy_req got %b exp 0", bus.req_out);
        else passed++;
        rd(ADDR_STATUS, v);
        total++;
        if (v !== 32'h18) $display("FAIL ack_busy_status got %h exp 18", v);
        else passed++;
        bus.ack_in = 1'b0;
        repeat (4) @(negedge clk);
        wr(ADDR_STATUS, 32'h08);
    endtask

    task automatic test_abort();
        logic seen = 1'b0;
        wr(ADDR_DATA, 32'h5A);
        wr(ADDR_CONTROL, 32'h1);
        total++;
        if (bus.req_out !== 1'b1) $display("FAIL abort_pre_req got %b exp 1", bus.req_out);
        else passed++;
        repeat (2) @(negedge clk);
        wr(ADDR_CONTROL, 32'h4);
        total++;
        if (bus.req_out !== 1'b0) $display("FAIL abort_req got %b exp 0", bus.req_out);
        else passed++;
        rd(ADDR_STATUS, v);
        total++;
        if (v !== 32'h0) $display("FAIL abort_status got %h exp 0", v);
        else passed++;
        wr(ADDR_CONTROL, 32'h5);
        for (int i = 0; i < 3; i++) begin
            seen = seen | bus.req_out;
            @(negedge clk);
        end
        total++;
        if (seen !== 1'b0) $display("FAIL abort_start_req got %b exp 0", seen);
        else passed++;
        rd(ADDR_STATUS, v);
        total++;
        if (v !== 32'h0) $display("FAIL abort_start_status got %h exp 0", v);
        else passed++;
    endtask

    task automatic test_mid_reset();
        logic [41:0] o;
        int n = 0;
        wr(ADDR_DATA, 32'h77);
        wr(ADDR_CONTROL, 32'h3);
        wr(ADDR_CONTROL, 32'h3);
        bus.ack_in = 1'b1;
        while (bus.req_out === 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        rd(ADDR_STATUS, v);
        total++;
        if (v !== 32'h19) $display("FAIL release_status got %h exp 19", v);
        else passed++;
        total++;
        if (bus.irq !== 1'b1) $display("FAIL release_irq got %b exp 1", bus.irq);
        else passed++;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        o = {bus.req_out, bus.irq, bus.data_out, bus.readdata};
        total++;
        if (o !== 42'h0) $display("FAIL midreset_outputs got %h exp 0", o);
        else passed++;
        bus.ack_in = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        rd(ADDR_STATUS, v);
        total++;
        if (v !== 32'h0) $display("FAIL postreset_status got %h exp 0", v);
        else passed++;
        rd(ADDR_CONTROL, v);
        total++;
        if (v !== 32'h0) $display("FAIL postreset_control got %h exp 0", v);
        else passed++;
        wr(ADDR_DATA, 32'h42);
        wr(ADDR_CONTROL, 32'h1);
        total++;
        if ({bus.req_out, bus.data_out} !== 9'h142)
            $display("FAIL postreset_start got %h exp 142", {bus.req_out, bus.data_out});
        else passed++;
        wr(ADDR_CONTROL, 32'h4);
    endtask

    task automatic test_sync_latency();
        int n = 0;
        @(negedge clk);
        bus.address = ADDR_STATUS;
        @(negedge clk);
        #2 bus.ack_in = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (bus.readdata[ST_ACK_SYNC] !== 1'b1 && n < 10);
        total++;
        if (n !== SS + 1) $display("FAIL sync_rise got %0d exp %0d", n, SS + 1);
        else passed++;
        n = 0;
        #2 bus.ack_in = 1'b0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.readdata[ST_ACK_SYNC] !== 1'b0 && n < 10);
        total++;
        if (n !== SS + 1) $display("FAIL sync_fall got %0d exp %0d", n, SS + 1);
        else passed++;
        wr(ADDR_TIMEOUT, 32'h1234);
        wr(ADDR_DATA, 32'h99);
        @(negedge clk);
        bus.address = ADDR_DATA;
        @(negedge clk);
        total++;
        if (bus.readdata !== 32'h99) $display("FAIL rd_data got %h exp 99", bus.readdata);
        else passed++;
        bus.address = ADDR_TIMEOUT;
        #1;
        total++;
        if (bus.readdata !== 32'h99) $display("FAIL rd_latency got %h exp 99", bus.readdata);
        else passed++;
        @(negedge clk);
        total++;
        if (bus.readdata !== 32'h1234) $display("FAIL rd_timeout got %h exp 1234", bus.readdata);
        else passed++;
        wr(ADDR_TIMEOUT, 32'h0);
    endtask

    task automatic test_unused_bits();
        wr(ADDR_CONTROL, 32'hFFFF_FFFF);
        total++;
        if (bus.req_out !== 1'b0) $display("FAIL allones_ctl_req got %b exp 0", bus.req_out);
        else passed++;
        rd(ADDR_CONTROL, v);
        total++;
        if (v !== 32'h2) $display("FAIL ctl_readback got %h exp 2", v);
        else passed++;
        rd(ADDR_STATUS, v);
        total++;
        if (v !== 32'h0) $display("FAIL allones_status got %h exp 0", v);
        else passed++;
        wr(ADDR_CONTROL, 32'h0);
        wr(ADDR_DATA, 32'hFFFF_FFFF);
        rd(ADDR_DATA, v);
        total++;
        if (v !== 32'hFF) $display("FAIL data_width got %h exp ff", v);
        else passed++;
        wr(ADDR_TIMEOUT, 32'hFFFF_FFFF);
        rd(ADDR_TIMEOUT, v);
        total++;
        if (v !== 32'hFFFF) $display("FAIL timeout_width got %h exp ffff", v);
        else passed++;
        wr(ADDR_TIMEOUT, 32'h0);
    endtask

    initial begin
        bus.address = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n = 1'b1;
        bus.writedata = 32'h0;
        bus.ack_in = 1'b0;
        test_reset();
        test_normal();
        test_timeout();
        test_busy();
        test_abort();
        test_mid_reset();
        test_sync_latency();
        test_unused_bits();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
